// File: rtl/tone_period_decoder_if.sv
// Signal bundle between the tone period decoder and its surroundings.
// The decoder side uses the slave modport; the stimulus/consumer side uses master.
// Optional TONE_DEC_ERR_EN adds the err_cnt status signal.
interface tone_period_decoder_if;
    logic       tick_en;
    logic       sig_in;
    logic [3:0] code;
    logic       valid;
    logic       locked;
`ifdef TONE_DEC_ERR_EN
    logic [7:0] err_cnt;

    modport master (
        output tick_en,
        output sig_in,
        input  code,
        input  valid,
        input  locked,
        input  err_cnt
    );

    modport slave (
        input  tick_en,
        input  sig_in,
        output code,
        output valid,
        output locked,
        output err_cnt
    );
`else
    modport master (
        output tick_en,
        output sig_in,
        input  code,
        input  valid,
        input  locked
    );

    modport slave (
        input  tick_en,
        input  sig_in,
        output code,
        output valid,
        output locked
    );
`endif
endinterface

// File: rtl/tone_period_decoder.sv
// Tone period decoder: measures the period of a square-wave tone in prescaler
// ticks, looks it up in the 16-entry key period table within +/-TOL ticks, and
// reports the recovered key code once STABLE_CNT consecutive periods agree.
// Build option TONE_DEC_ERR_EN adds an 8-bit saturating error counter
// (no-match results and timeouts).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no tone seen yet / timed out; counter held at 0
// ST_MEASURE | counting ticks between rising edges, capturing each period
module tone_period_decoder #(
    parameter int TOL        = 3,
    parameter int STABLE_CNT = 2,
    parameter int CNT_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    tone_period_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
    localparam logic [3:0]       RUN_MAX = 4'(STABLE_CNT);

    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             w_rise;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_capture;
    logic             w_timeout;

    logic [CNT_W-1:0] r_period;
    logic [4:0]       r_idx;
    logic             r_busy;
    logic             r_found;
    logic [3:0]       r_hit;
    logic [CNT_W-1:0] w_entry;
    logic [CNT_W-1:0] w_diff;
    logic             w_match;
    logic             w_result;

    logic [3:0]       r_cand;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [3:0]       r_code;
    logic             r_locked;
    logic             r_valid;

    function automatic logic [CNT_W-1:0] period_tbl(input logic [3:0] i_idx);
        case (i_idx)
            4'd0:    return CNT_W'(1666);
            4'd1:    return CNT_W'(999);
            4'd2:    return CNT_W'(666);
            4'd3:    return CNT_W'(499);
            4'd4:    return CNT_W'(399);
            4'd5:    return CNT_W'(332);
            4'd6:    return CNT_W'(285);
            4'd7:    return CNT_W'(249);
            4'd8:    return CNT_W'(221);
            4'd9:    return CNT_W'(199);
            4'd10:   return CNT_W'(181);
            4'd11:   return CNT_W'(165);
            4'd12:   return CNT_W'(152);
            4'd13:   return CNT_W'(141);
            4'd14:   return CNT_W'(132);
            default: return CNT_W'(124);
        endcase
    endfunction

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_cnt_inc = (bus.tick_en && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;

    // Synchronize the pin, register FSM state and the period counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= bus.sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter update, capture and timeout decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A rise in the saturating cycle still captures (as 2047).
                if (w_rise) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc == CNT_MAX) begin
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_entry  = period_tbl(r_idx[3:0]);
    assign w_diff   = (r_period >= w_entry) ? (r_period - w_entry) : (w_entry - r_period);
    assign w_match  = (w_diff <= TOL_V);
    // idx reaches 16 one clk after the last entry was examined: that is the
    // result cycle, 17 clks after the capture.
    assign w_result = r_busy && r_idx[4] && !w_capture;

    // Sequential table search, one entry per clk; a new capture restarts it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_period <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_found  <= 1'b0;
            r_hit    <= '0;
        end else if (w_capture) begin
            r_period <= w_cnt_inc;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_found  <= 1'b0;
        end else if (r_busy) begin
            if (r_idx[4]) begin
                r_busy <= 1'b0;
            end else begin
                if (w_match && !r_found) begin
                    r_found <= 1'b1;
                    r_hit   <= r_idx[3:0];
                end
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    // Run length of the candidate code for the result being applied
    always_comb begin
        w_run_nxt = 4'd1;
        if (r_hit == r_cand) begin
            w_run_nxt = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
        end
    end

    // Apply search results and timeouts to candidate, run, code and lock
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cand   <= '0;
            r_run    <= '0;
            r_code   <= '0;
            r_locked <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_timeout) begin
                r_run    <= '0;
                r_locked <= 1'b0;
            end else if (w_result) begin
                if (!r_found) begin
                    r_run    <= '0;
                    r_locked <= 1'b0;
                end else begin
                    r_cand <= r_hit;
                    r_run  <= w_run_nxt;
                    if (w_run_nxt == RUN_MAX) begin
                        // Already locked on this code: stay quiet.
                        if (!(r_locked && (r_hit == r_code))) begin
                            r_code   <= r_hit;
                            r_locked <= 1'b1;
                            r_valid  <= 1'b1;
                        end
                    end else begin
                        r_locked <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef TONE_DEC_ERR_EN
    logic [7:0] r_err_cnt;
    logic       w_err_evt;

    assign w_err_evt = w_timeout || (w_result && !r_found);

    // Saturating count of unmatched periods and timeouts
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

    assign bus.code   = r_code;
    assign bus.valid  = r_valid;
    assign bus.locked = r_locked;

endmodule
